// File: rtl/spi_debug_pkg.sv
// Shared opcodes, state encodings and status-byte layout for the SPI debug target.
package spi_debug_pkg;

  localparam logic [7:0] OP_WRITE  = 8'h02;
  localparam logic [7:0] OP_READ   = 8'h03;
  localparam logic [7:0] OP_STATUS = 8'h05;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_OPCODE = 3'd1,
    S_ADDR   = 3'd2,
    S_WDATA  = 3'd3,
    S_DUMMY  = 3'd4,
    S_RDATA  = 3'd5,
    S_STATUS = 3'd6,
    S_IGNORE = 3'd7
  } frame_state_e;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_WAIT = 1'b1
  } bus_state_e;

  localparam int unsigned STAT_BUSY = 0;
  localparam int unsigned STAT_ERR  = 1;
  localparam int unsigned STAT_TMO  = 2;

  function automatic logic [7:0] status_byte(input logic tmo, input logic err, input logic busy);
    logic [7:0] s;
    s            = '0;
    s[STAT_BUSY] = busy;
    s[STAT_ERR]  = err;
    s[STAT_TMO]  = tmo;
    return s;
  endfunction

endpackage

// File: rtl/spi_debug_target_if.sv
// Single-beat 32-bit memory initiator bus, same shape as the vproc memory port.
interface spi_debug_target_if;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rvalid;
  logic        err;
  logic [31:0] rdata;

  modport master (output req, addr, we, be, wdata, input rvalid, err, rdata);
  modport slave  (input req, addr, we, be, wdata, output rvalid, err, rdata);
endinterface

// File: rtl/spi_target_sync.sv
// Synchronizes the asynchronous SPI pins into clk and derives SCK/CS edge pulses.
module spi_target_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic cs_n_i,
  input  logic sck_i,
  input  logic mosi_i,
  output logic mosi_o,
  output logic sck_rise_o,
  output logic sck_fall_o,
  output logic cs_fall_o,
  output logic cs_rise_o
);
  import spi_debug_pkg::*;

  logic [SYNC_STAGES-1:0] cs_q, sck_q, mosi_q;
  logic                   cs_prev_q, sck_prev_q;

  // cs_n resets to its idle (high) level so leaving reset never fakes a frame start.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cs_q       <= '1;
      sck_q      <= '0;
      mosi_q     <= '0;
      cs_prev_q  <= 1'b1;
      sck_prev_q <= 1'b0;
    end else begin
      cs_q       <= {cs_q[SYNC_STAGES-2:0], cs_n_i};
      sck_q      <= {sck_q[SYNC_STAGES-2:0], sck_i};
      mosi_q     <= {mosi_q[SYNC_STAGES-2:0], mosi_i};
      cs_prev_q  <= cs_q[SYNC_STAGES-1];
      sck_prev_q <= sck_q[SYNC_STAGES-1];
    end
  end

  assign mosi_o     = mosi_q[SYNC_STAGES-1];
  assign sck_rise_o =  sck_q[SYNC_STAGES-1] & ~sck_prev_q;
  assign sck_fall_o = ~sck_q[SYNC_STAGES-1] &  sck_prev_q;
  assign cs_fall_o  = ~cs_q[SYNC_STAGES-1]  &  cs_prev_q;
  assign cs_rise_o  =  cs_q[SYNC_STAGES-1]  & ~cs_prev_q;

endmodule

// File: rtl/spi_debug_target.sv
// SPI mode-0 responder turning host frames into single 32-bit memory transactions.
module spi_debug_target #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned DUMMY_BITS     = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic spi_cs_n,
  input  logic spi_sck,
  input  logic spi_mosi,
  output logic spi_miso,
  spi_debug_target_if.master mem
);
  import spi_debug_pkg::*;

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [5:0]    DUMMY_LAST = 6'(DUMMY_BITS - 1);

  logic mosi_s, sck_rise, sck_fall, cs_fall, cs_rise;

  spi_target_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .rst        (rst),
    .cs_n_i     (spi_cs_n),
    .sck_i      (spi_sck),
    .mosi_i     (spi_mosi),
    .mosi_o     (mosi_s),
    .sck_rise_o (sck_rise),
    .sck_fall_o (sck_fall),
    .cs_fall_o  (cs_fall),
    .cs_rise_o  (cs_rise)
  );

  frame_state_e  state_q, state_d;
  bus_state_e    bus_q, bus_d;
  logic [5:0]    cnt_q, cnt_d;
  logic [31:0]   shift_q, shift_d;
  logic [31:0]   tx_q, tx_d;
  logic          miso_q, miso_d;
  logic          start_q, start_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          rdata_vld_q, rdata_vld_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          err_q, err_d;
  logic          tmo_q, tmo_d;
  logic          busy;

  assign busy = (bus_q == BUS_WAIT);

  always_comb begin
    state_d     = state_q;
    bus_d       = bus_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    miso_d      = miso_q;
    start_d     = 1'b0;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    rdata_vld_d = rdata_vld_q;
    tmo_cnt_d   = tmo_cnt_q;
    err_d       = err_q;
    tmo_d       = tmo_q;

    // Frame FSM runs first so that flag sets from the bus FSM below win over a status-read clear.
    if (cs_rise) begin
      state_d = S_IDLE;
      miso_d  = 1'b0;
    end else if (cs_fall) begin
      state_d = S_OPCODE;
      cnt_d   = '0;
      miso_d  = 1'b0;
    end else if (sck_rise && state_q != S_IDLE) begin
      shift_d = {shift_q[30:0], mosi_s};
      cnt_d   = cnt_q + 6'd1;
      unique case (state_q)
        S_OPCODE: if (cnt_q == 6'd7) begin
          cnt_d = '0;
          if (shift_d[7:0] == OP_WRITE || shift_d[7:0] == OP_READ) begin
            if (busy) begin
              state_d = S_IGNORE;
              err_d   = 1'b1;
            end else begin
              state_d = S_ADDR;
              we_d    = (shift_d[7:0] == OP_WRITE);
            end
          end else if (shift_d[7:0] == OP_STATUS) begin
            state_d = S_STATUS;
            tx_d    = {status_byte(tmo_q, err_q, busy), 24'h0};
          end else begin
            state_d = S_IGNORE;
          end
        end
        S_ADDR: if (cnt_q == 6'd31) begin
          cnt_d  = '0;
          addr_d = shift_d;
          if (we_q) begin
            state_d = S_WDATA;
          end else begin
            state_d     = S_DUMMY;
            start_d     = 1'b1;
            rdata_vld_d = 1'b0;
          end
        end
        S_WDATA: if (cnt_q == 6'd31) begin
          state_d = S_IGNORE;
          wdata_d = shift_d;
          start_d = 1'b1;
        end
        S_DUMMY: if (cnt_q == DUMMY_LAST) begin
          cnt_d   = '0;
          state_d = S_RDATA;
          if (rdata_vld_q) begin
            tx_d = rdata_q;
          end else begin
            tx_d  = '1;
            err_d = 1'b1;
          end
        end
        S_RDATA:  if (cnt_q == 6'd31) state_d = S_IGNORE;
        S_STATUS: if (cnt_q == 6'd7) begin
          state_d = S_IGNORE;
          err_d   = 1'b0;
          tmo_d   = 1'b0;
        end
        default: ;
      endcase
    end else if (sck_fall) begin
      if (state_q == S_STATUS || state_q == S_RDATA) begin
        miso_d = tx_q[31];
        tx_d   = {tx_q[30:0], 1'b0};
      end else begin
        miso_d = 1'b0;
      end
    end

    unique case (bus_q)
      BUS_IDLE: if (start_q) begin
        req_d     = 1'b1;
        bus_d     = BUS_WAIT;
        tmo_cnt_d = '0;
      end
      BUS_WAIT: if (mem.rvalid) begin
        req_d = 1'b0;
        bus_d = BUS_IDLE;
        if (mem.err) err_d = 1'b1;
        if (!we_q) begin
          rdata_d     = mem.err ? '1 : mem.rdata;
          rdata_vld_d = 1'b1;
        end
      end else if (tmo_cnt_q == TMO_LAST) begin
        req_d = 1'b0;
        bus_d = BUS_IDLE;
        tmo_d = 1'b1;
      end else begin
        tmo_cnt_d = tmo_cnt_q + TW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      bus_q       <= BUS_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      tx_q        <= '0;
      miso_q      <= 1'b0;
      start_q     <= 1'b0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rdata_vld_q <= 1'b0;
      tmo_cnt_q   <= '0;
      err_q       <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_q       <= bus_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      miso_q      <= miso_d;
      start_q     <= start_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      rdata_vld_q <= rdata_vld_d;
      tmo_cnt_q   <= tmo_cnt_d;
      err_q       <= err_d;
      tmo_q       <= tmo_d;
    end
  end

  assign spi_miso  = miso_q & ~spi_cs_n;
  assign mem.req   = req_q;
  assign mem.addr  = addr_q;
  assign mem.we    = we_q;
  assign mem.be    = {4{req_q}};
  assign mem.wdata = wdata_q;

endmodule
